// File: rtl/param_ram.sv
`default_nettype none
// ============================================================================
// Module   : param_ram
// Brief    : Simple dual-port byte-enabled RAM with self-clearing controller,
//            registered read data and selectable read-during-write policy.
// Revision : 1.0 - initial release
// ============================================================================
module param_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int RD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic                q_valid_q, q_valid_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                w_accept;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic [BE_W-1:0]     w_mem_be;
    logic [DATA_W-1:0]   w_rd_old;
    logic [DATA_W-1:0]   w_rd_word;

    // A clear request on the same edge pre-empts any user access.
    assign w_accept = ready_q && !clear;
    assign w_wr_acc = w_accept && wr_en;
    assign w_rd_acc = w_accept && rd_en;

    // The clear sequencer owns the write port for the whole CLEAR state.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        w_mem_be   = wr_be;
        if (state_q == ST_CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = clr_cnt_q;
            w_mem_data = '0;
            w_mem_be   = '1;
        end else if (w_wr_acc) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_mem_be[i]) begin
                    mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_old = mem[rd_addr];

    generate
        if (RD_MODE == 1) begin : g_write_first
            logic [DATA_W-1:0] w_rd_merged;

            always_comb begin
                w_rd_merged = w_rd_old;
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) begin
                        w_rd_merged[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end

            assign w_rd_word = (w_wr_acc && (wr_addr == rd_addr)) ? w_rd_merged : w_rd_old;
        end else begin : g_read_first
            assign w_rd_word = w_rd_old;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase

        if (w_rd_acc) begin
            q_d       = w_rd_word;
            q_valid_d = 1'b1;
        end

        ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign ready   = ready_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_param_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_ram
// Brief    : Directed bench for param_ram; read-first and write-first
//            instances are driven in lockstep from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_ram;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr;

    logic        rdy0, rdy1;
    logic [31:0] q0, q1;
    logic        qv0, qv1;

    int n_tests = 0;
    int n_fail  = 0;

    param_ram #(.DATA_W(32), .ADDR_W(5), .RD_MODE(0)) u_dut_rf (
        .clk(clk), .rst(rst), .clear(clear), .ready(rdy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .q(q0), .q_valid(qv0)
    );

    param_ram #(.DATA_W(32), .ADDR_W(5), .RD_MODE(1)) u_dut_wf (
        .clk(clk), .rst(rst), .clear(clear), .ready(rdy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .q(q1), .q_valid(qv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [3:0]  wr_be;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic        exp_qv;
        logic [31:0] exp_q0;
        logic [31:0] exp_q1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [3:0] be,
                                input logic [31:0] wd, input logic re, input logic [4:0] ra,
                                input logic eqv, input logic [31:0] eq0, input logic [31:0] eq1);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_be = be; v.wr_data = wd;
        v.rd_en = re; v.rd_addr = ra; v.exp_qv = eqv; v.exp_q0 = eq0; v.exp_q1 = eq1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_both(input string name, input logic [31:0] e_q0, input logic [31:0] e_q1,
                            input logic e_qv, input logic e_rdy);
        chk({name, " q(rf)"},  q0, e_q0);
        chk({name, " q(wf)"},  q1, e_q1);
        chk({name, " qv(rf)"}, {31'b0, qv0}, {31'b0, e_qv});
        chk({name, " qv(wf)"}, {31'b0, qv1}, {31'b0, e_qv});
        chk({name, " rdy(rf)"}, {31'b0, rdy0}, {31'b0, e_rdy});
        chk({name, " rdy(wf)"}, {31'b0, rdy1}, {31'b0, e_rdy});
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic re, input logic [4:0] ra,
                         input logic clr);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra; clear = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle();

        // Table: reads after the power-up clear, byte enables, read-during-write.
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'd5, 1, 32'h0, 32'h0));
        for (int a = 0; a < 32; a++)
            vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'(a), 1, 32'h0, 32'h0));
        vecs.push_back(mk(1, 5'd3, 4'hF, 32'hAABBCCDD, 0, 5'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 5'd3, 4'b0101, 32'h11223344, 0, 5'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'd3, 1, 32'hAA22CC44, 32'hAA22CC44));
        vecs.push_back(mk(1, 5'd7, 4'hF, 32'h12345678, 1, 5'd3, 1, 32'hAA22CC44, 32'hAA22CC44));
        vecs.push_back(mk(1, 5'd7, 4'b0011, 32'hFFFFFFFF, 1, 5'd7, 1, 32'h12345678, 32'h1234FFFF));
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'd7, 1, 32'h1234FFFF, 32'h1234FFFF));
        vecs.push_back(mk(1, 5'd7, 4'h0, 32'h0, 1, 5'd7, 1, 32'h1234FFFF, 32'h1234FFFF));
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'd7, 1, 32'h1234FFFF, 32'h1234FFFF));
        vecs.push_back(mk(1, 5'd9, 4'hF, 32'hCAFEF00D, 1, 5'd3, 1, 32'hAA22CC44, 32'hAA22CC44));
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 1, 5'd9, 1, 32'hCAFEF00D, 32'hCAFEF00D));
        vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0, 0, 5'd0, 0, 32'hCAFEF00D, 32'hCAFEF00D));

        // Reset state
        #1 rst = 1'b1;
        #1 chk_both("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Power-up clear timing, with accesses attempted near its end
        for (int i = 1; i <= 32; i++) begin
            if (i >= 29) drive(1, 5'd5, 4'hF, 32'hDEADBEEF, 1, 5'd5, 0);
            else         idle();
            cycle();
            chk_both($sformatf("init_clear e%0d", i), 32'h0, 32'h0, 1'b0, (i == 32));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_be, vecs[i].wr_data,
                  vecs[i].rd_en, vecs[i].rd_addr, 1'b0);
            cycle();
            chk_both($sformatf("vec%0d", i), vecs[i].exp_q0, vecs[i].exp_q1, vecs[i].exp_qv, 1'b1);
        end

        // Runtime clear after filling with ones
        for (int a = 0; a < 32; a++) begin
            drive(1, 5'(a), 4'hF, 32'hFFFFFFFF, 0, 5'd0, 0);
            cycle();
        end
        drive(1, 5'd9, 4'hF, 32'h00000001, 1, 5'd9, 1);
        cycle();
        chk_both("clear_edge", 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            idle();
            if (i == 10 || i == 20) clear = 1'b1;
            cycle();
            chk_both($sformatf("rt_clear e%0d", i), 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, (i == 32));
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 5'd0, 4'h0, 32'h0, 1, 5'(a), 0);
            cycle();
            chk_both($sformatf("rt_read a%0d", a), 32'h0, 32'h0, 1'b1, 1'b1);
        end

        // Reset in the middle of a clear sequence
        drive(1, 5'd4, 4'hF, 32'h5A5A5A5A, 0, 5'd0, 0);
        cycle();
        drive(0, 5'd0, 4'h0, 32'h0, 1, 5'd4, 0);
        cycle();
        chk_both("pre_rst read", 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b1);
        drive(0, 5'd0, 4'h0, 32'h0, 0, 5'd0, 1);
        cycle();
        idle();
        for (int i = 1; i <= 20; i++) cycle();
        rst = 1'b1;
        #1 chk_both("mid_clear rst", 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            cycle();
            chk_both($sformatf("rst_clear e%0d", i), 32'h0, 32'h0, 1'b0, (i == 32));
        end
        drive(0, 5'd0, 4'h0, 32'h0, 1, 5'd4, 0);
        cycle();
        chk_both("post_rst a4", 32'h0, 32'h0, 1'b1, 1'b1);
        drive(0, 5'd0, 4'h0, 32'h0, 1, 5'd31, 0);
        cycle();
        chk_both("post_rst a31", 32'h0, 32'h0, 1'b1, 1'b1);
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
